// File: rtl/simple_fifo_ext_if.sv
// rtl/simple_fifo_ext_if.sv - write/read/status bundle for simple_fifo_ext
interface simple_fifo_ext_if #(
  parameter int WIDTH     = 128,
  parameter int DEPTH_LOG = 3
);
  logic                 we;
  logic [WIDTH-1:0]     din;
  logic                 re;
  logic                 flush;
  logic                 err_clr;
  logic [WIDTH-1:0]     dout;
  logic                 empty;
  logic                 full;
  logic                 almost_empty;
  logic                 almost_full;
  logic [DEPTH_LOG:0]   count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output we, din, re, flush, err_clr,
    input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  we, din, re, flush, err_clr,
    output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/simple_fifo_ext.sv
// rtl/simple_fifo_ext.sv - single-clock register FIFO, standard or FWFT read,
// programmable almost flags, flush and sticky overflow/underflow
module simple_fifo_ext #(
  parameter int WIDTH     = 128,
  parameter int DEPTH_LOG = 3,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1
) (
  input  logic             clk,
  input  logic             reset,
  simple_fifo_ext_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] C_DEPTH  = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] C_AFULL  = (DEPTH_LOG + 1)'(AFULL_TH);
  localparam logic [DEPTH_LOG:0] C_AEMPTY = (DEPTH_LOG + 1)'(AEMPTY_TH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG-1:0] r_wr_ptr;
  logic [DEPTH_LOG-1:0] r_rd_ptr;
  logic [DEPTH_LOG:0]   r_count;
  logic                 r_overflow;
  logic                 r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [WIDTH-1:0] w_dout;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);
  // flush overrides every same-cycle request, including error detection
  assign w_wr_acc  = bus.we && !w_full  && !bus.flush;
  assign w_rd_acc  = bus.re && !w_empty && !bus.flush;
  assign w_ovf_set = bus.we && w_full   && !bus.flush;
  assign w_unf_set = bus.re && w_empty  && !bus.flush;

  always_ff @(posedge clk) begin
    if (w_wr_acc && !reset) begin
      r_mem[r_wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set || (r_overflow  && !bus.err_clr);
      r_underflow <= w_unf_set || (r_underflow && !bus.err_clr);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign w_dout = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_dout <= '0;
        else if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
      end
      assign w_dout = r_dout;
    end
  endgenerate

  assign bus.dout         = w_dout;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_empty = (r_count <= C_AEMPTY);
  assign bus.almost_full  = (r_count >= C_AFULL);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_simple_fifo_ext.sv
// tb/tb_simple_fifo_ext.sv - standard and FWFT instances driven identically,
// checked against a queue model
module tb_simple_fifo_ext;
  localparam int W = 8;
  localparam int DL = 3;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         we = 1'b0;
  logic [W-1:0] din = '0;
  logic         re = 1'b0;
  logic         flush = 1'b0;
  logic         err_clr = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_ovf;
  logic         m_unf;

  always #5 clk = ~clk;

  simple_fifo_ext_if #(.WIDTH(W), .DEPTH_LOG(DL)) bus_s ();
  simple_fifo_ext_if #(.WIDTH(W), .DEPTH_LOG(DL)) bus_f ();

  assign bus_s.we = we;       assign bus_f.we = we;
  assign bus_s.din = din;     assign bus_f.din = din;
  assign bus_s.re = re;       assign bus_f.re = re;
  assign bus_s.flush = flush; assign bus_f.flush = flush;
  assign bus_s.err_clr = err_clr; assign bus_f.err_clr = err_clr;

  simple_fifo_ext #(.WIDTH(W), .DEPTH_LOG(DL), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(1))
    u_std (.clk(clk), .reset(reset), .bus(bus_s));
  simple_fifo_ext #(.WIDTH(W), .DEPTH_LOG(DL), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(1))
    u_fwft (.clk(clk), .reset(reset), .bus(bus_f));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_edge();
    int n;
    logic wr, rd;
    n = q.size();
    wr = we && (n < DEPTH) && !flush;
    rd = re && (n > 0) && !flush;
    m_ovf = (we && n == DEPTH && !flush) || (m_ovf && !err_clr);
    m_unf = (re && n == 0 && !flush) || (m_unf && !err_clr);
    if (flush) q.delete();
    else begin
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(din);
    end
  endtask

  task automatic check_all();
    int n;
    logic [W-1:0] fw;
    n = q.size();
    fw = (n > 0) ? q[0] : '0;
    check("count",   32'(bus_s.count), 32'(n));
    check("count_f", 32'(bus_f.count), 32'(n));
    check("empty",   32'(bus_s.empty), 32'(n == 0));
    check("full",    32'(bus_s.full),  32'(n == DEPTH));
    check("aempty",  32'(bus_s.almost_empty), 32'(n <= 1));
    check("afull",   32'(bus_s.almost_full),  32'(n >= 6));
    check("ovf",     32'(bus_s.overflow),  32'(m_ovf));
    check("unf",     32'(bus_s.underflow), 32'(m_unf));
    check("ovf_f",   32'(bus_f.overflow),  32'(m_ovf));
    check("dout_std",  32'(bus_s.dout), 32'(m_dout));
    check("dout_fwft", 32'(bus_f.dout), 32'(fw));
  endtask

  task automatic step(input logic i_we, input logic [W-1:0] i_din, input logic i_re,
                      input logic i_flush, input logic i_clr);
    we = i_we; din = i_din; re = i_re; flush = i_flush; err_clr = i_clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    @(negedge clk);
    check_all();

    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
    check("t1_full", 32'(bus_s.full), 32'd1);
    step(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    check("t1_ovf", 32'(bus_s.overflow), 32'd1);
    check("t1_cnt", 32'(bus_s.count), 32'd8);

    for (int i = 1; i <= 8; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("t2_dout", 32'(bus_s.dout), 32'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t2_unf", 32'(bus_s.underflow), 32'd1);
    check("t2_hold", 32'(bus_s.dout), 32'h08);

    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    check("t3_fwft", 32'(bus_f.dout), 32'hAA);
    check("t3_empty", 32'(bus_f.empty), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t3_zero", 32'(bus_f.dout), 32'd0);

    for (int i = 0; i < 4; i++) step(1'b1, W'(8'h10 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, W'(8'h20 + i), 1'b1, 1'b0, 1'b0);
    check("t4_cnt", 32'(bus_s.count), 32'd4);
    check("t4_head", 32'(bus_f.dout), 32'h30);

    step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h41, 1'b1, 1'b1, 1'b0);
    check("t5_cnt", 32'(bus_s.count), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t5_unf", 32'(bus_s.underflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("t5_clr", 32'(bus_s.underflow), 32'd0);

    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    we = 1'b1; din = 8'h63;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    we = 1'b0;
    @(negedge clk);
    check_all();
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    check("t6_fwft", 32'(bus_f.dout), 32'h55);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t6_std", 32'(bus_s.dout), 32'h55);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, W'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
